// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding and limits for the APB register file front-end
package apb_pkg;
    typedef enum logic {IDLE, ACCESS} apb_state_e;
    localparam int MaxWaitStates = 15;
endpackage

// File: rtl/apb_regfile_ctrl.sv
// apb_regfile_ctrl: APB slave front-end with wait states and range check,
// driving the write port and combinational read port of an 8-bit register file.
module apb_regfile_ctrl
    import apb_pkg::*;
#(
    parameter int NumWords = 64,
    parameter int AddrWidth = 8,
    parameter int WaitStates = 0,
    localparam int OffW = $clog2(NumWords),
    localparam int WaitW = (WaitStates == 0) ? 1 : $clog2(WaitStates + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [AddrWidth-1:0] paddr,
    input  logic [7:0]           pwdata,
    output logic [7:0]           prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic                 rf_w_en,
    output logic [OffW-1:0]      rf_offset,
    output logic [7:0]           rf_data_in,
    input  logic [7:0]           rf_data_out
);
    localparam logic [AddrWidth:0] Limit = (AddrWidth + 1)'(NumWords);

    apb_state_e           state_q, state_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic                 write_q, write_d;
    logic                 err, done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
        end
    end

    // Extend by one bit so NumWords == 2**AddrWidth still compares correctly
    assign err  = {1'b0, addr_q} >= Limit;
    assign done = (state_q == ACCESS) && psel && penable && (wait_q == '0);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = write_q;
        if (state_q == IDLE) begin
            if (psel && !penable) begin
                state_d = ACCESS;
                wait_d  = WaitW'(WaitStates);
                addr_d  = paddr;
                data_d  = pwdata;
                write_d = pwrite;
            end
        end else if (!(psel && penable) || done) begin
            state_d = IDLE;
        end else begin
            wait_d = wait_q - 1'b1;
        end
    end

    assign pready     = done;
    assign pslverr    = done && err;
    assign rf_w_en    = done && write_q && !err;
    assign prdata     = (done && !write_q && !err) ? rf_data_out : '0;
    assign rf_offset  = (state_q == ACCESS) ? addr_q[OffW-1:0] : '0;
    assign rf_data_in = (state_q == ACCESS) ? data_q : '0;
endmodule

// File: doc/apb_regfile_ctrl.md
# apb_regfile_ctrl

APB slave front-end for the 8-bit register file of the APB project. It decodes APB setup/access phases, inserts a configurable number of wait states, and range-checks the address. It drives the register file's write-enable, offset and write-data, and returns read data and slave-error on the APB bus. It sits directly upstream of the register file, between the APB interconnect and the storage.

## Interface
- NumWords, 64: register file depth; must match the attached register file.
- AddrWidth, 8: PADDR width; must satisfy AddrWidth >= $clog2(NumWords).
- WaitStates, 0: wait cycles inserted before PREADY in every access phase (0..15).

- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  AddrWidth  byte address; word index = paddr.
- pwdata  in  8  write data.
- prdata  out  8  read data, valid only while pready=1 and pwrite=0.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error flag, valid only while pready=1.
- rf_w_en  out  1  register file write enable.
- rf_offset  out  $clog2(NumWords)  register file word index.
- rf_data_in  out  8  register file write data.
- rf_data_out  in  8  register file combinational read data.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE:
  - psel=1, penable=0 (setup): latch paddr, pwrite, pwdata; load wait_cnt=WaitStates; go to ACCESS.
  - Any other input, including psel=1 with penable=1 without a prior setup: stay in IDLE with all outputs low.
- ACCESS:
  - psel=1, penable=1, wait_cnt!=0: decrement wait_cnt; pready=0.
  - psel=1, penable=1, wait_cnt==0: completing cycle. Assert pready=1 and go to IDLE.
  - psel=0 or penable=0: protocol abort. Return to IDLE; no write; pready stays 0.
- Range check: err = (latched paddr >= NumWords). Compare at full AddrWidth; no truncation before the compare.
- Completing cycle, write, no err: rf_w_en=1; the register file captures rf_data_in at the closing edge.
- Completing cycle, read, no err: prdata = rf_data_out (combinational through the latched offset).
- Completing cycle with err: pslverr=1, rf_w_en=0, prdata=0.
- rf_offset = latched paddr truncated to $clog2(NumWords) bits.
- rf_data_in = latched pwdata.
- Outside the completing cycle: prdata=0, pslverr=0, rf_w_en=0.
- The register file's active-low reset is tied to ~reset at the integration level.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, wait_cnt=0, latched address/data/direction = 0.
  - pready=0, pslverr=0, prdata=0, rf_w_en=0, rf_offset=0, rf_data_in=0.
- Latency: setup in cycle T0 → pready in cycle T1+WaitStates. With WaitStates=0 this is a zero-wait APB transfer.
- Write takes effect at the rising edge that ends the pready cycle. A read issued in the next transfer returns the new value.
- Back-to-back transfers: a new setup is accepted in the cycle immediately after the pready cycle. Throughput is one transfer per 2+WaitStates cycles.
- pwdata/paddr changes during ACCESS are ignored; only values latched at setup are used.
- Reset mid-ACCESS: transfer dropped, no write, all outputs low from reset assertion.
- wait_cnt width = max(1, $clog2(WaitStates+1)); it never underflows.

## Structure
- apb_pkg holds:
  - typedef enum logic {IDLE, ACCESS} apb_state_e
  - localparam int MaxWaitStates = 15
- Single module, no sub-modules. The integration wrapper instantiates this block plus the register file.

## Test plan
- Write 0xA5 to paddr 0x03, WaitStates=0 → pready=1 in T1; rf_w_en=1 for one cycle with rf_offset=3, rf_data_in=0xA5. A following read of 0x03 → prdata=0xA5, pslverr=0.
- WaitStates=3, read paddr 0x10 holding 0x5C → pready low for 3 access cycles; pready=1 in the 4th with prdata=0x5C.
- Write 0x77 to paddr 0x40 (NumWords=64) → pready=1, pslverr=1, rf_w_en stays 0. Reading 0x00..0x3F afterwards shows no change.
- Setup then psel deasserted before penable → FSM returns to IDLE; no rf_w_en pulse; pready never asserts.
- Assert reset during the 2nd wait cycle of a write (WaitStates=3) → all outputs 0 immediately; no write occurs; a fresh transfer after release completes normally.
